data_mem_responder: RTL

Responder end of the CPU data-memory load/store interface. It accepts one load or store request at a time over a valid/ready handshake, waits a programmable number of cycles, then performs the access on an internal byte-addressable little-endian word array. It returns the result over a second valid/ready handshake. It sits beside the CPU datapath as the data memory, opposite the load/store request logic.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_lane_align.sv | 51 +++++
 rtl/data_mem_responder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the data-memory responder.
package mem_pkg;

    // Access-size encodings carried on req_funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width of the WAIT-state down-counter
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for little-endian sub-word loads and stores.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

    // Replicate store data into every lane; the byte enables pick the live lanes
    always_comb begin
        o_be       = 4'b0000;
        o_wword    = 32'h0;
        o_rdata    = 32'h0;
        o_misalign = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wword = {4{i_wdata[7:0]}};
                o_rdata = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte}
                                             : {24'h0, w_byte};
            end
            F3_H, F3_HU: begin
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wword    = {2{i_wdata[15:0]}};
                o_rdata    = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half}
                                                : {16'h0, w_half};
                o_misalign = i_addr_lo[0];
            end
            F3_W: begin
                o_be       = 4'b1111;
                o_wword    = i_wdata;
                o_rdata    = i_rword;
                o_misalign = (i_addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, programmable wait, then access.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t           r_state;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [2:0]       r_f3;

    logic [31:0]      r_mem [DEPTH_WORDS];

    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rword;
    logic [3:0]       w_be;
    logic [31:0]      w_wword;
    logic [31:0]      w_ldata;
    logic             w_misalign;
    logic             w_range_err;
    logic             w_f3_err;
    logic             w_err;

    assign w_idx   = r_addr[IDX_W+1:2];
    assign w_rword = r_mem[w_idx];

    mem_lane_align u_align (
        .i_addr_lo  (r_addr[1:0]),
        .i_funct3   (r_f3),
        .i_wdata    (r_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wword    (w_wword),
        .o_rdata    (w_ldata),
        .o_misalign (w_misalign)
    );

    // Reject misaligned, out-of-range and unsupported size/direction combinations
    always_comb begin
        w_range_err = (r_addr[31:2] >= 30'(DEPTH_WORDS));
        w_f3_err    = (r_f3 == 3'b011) || (r_f3 == 3'b110) || (r_f3 == 3'b111) ||
                      (r_we && ((r_f3 == F3_BU) || (r_f3 == F3_HU)));
        w_err       = w_misalign || w_range_err || w_f3_err;
    end

    // Control FSM with registered handshake outputs and response data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= 32'h0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_f3         <= 3'b000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_f3        <= req_funct3;
                        r_req_ready <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            r_state <= WAIT;
                            r_cnt   <= WAIT_INIT;
                        end else begin
                            r_state <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) r_state <= ACCESS;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                ACCESS: begin
                    r_err        <= w_err;
                    r_rdata      <= (w_err || r_we) ? 32'h0 : w_ldata;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Store commit on the ACCESS exit edge; memory contents are never reset
    always_ff @(posedge clk) begin
        if (r_state == ACCESS && r_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
